// File: rtl/instruction_fetch.sv
// Fetch stage feeding the decoder: reads one or two program words per instruction
// and presents them for exactly two cycles, with a NOP drain cycle between windows.
module instruction_fetch #(
   parameter int word_size = 16,
   parameter int addr_width = 16,
   parameter logic [addr_width-1:0] reset_vector = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  run,
   input  logic                  pc_reset,
   input  logic                  ir_reset,
   output logic [addr_width-1:0] mem_addr,
   output logic                  mem_read_enable,
   input  logic [word_size-1:0]  mem_data,
   input  logic                  mem_ready,
   output logic [word_size-1:0]  instruction,
   output logic [word_size-1:0]  pre_data,
   output logic                  instr_valid,
   output logic [addr_width-1:0] pc
);

   typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_DAT, ISSUE, EXEC, DRAIN} state_t;

   state_t                  state, state_next;
   logic [addr_width-1:0]   pc_q, pc_next;
   logic [word_size-1:0]    opcode_q, opcode_next;
   logic [word_size-1:0]    operand_q, operand_next;
   logic [word_size-1:0]    instruction_next, pre_data_next;
   logic                    valid_next, read_next;
   logic                    fetch_done;

   function automatic logic is_two_word(input logic [7:0] op);
      case (op)
         8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h13: is_two_word = 1'b1;
         default: is_two_word = (op >= 8'h19) && (op <= 8'h1F);
      endcase
   endfunction

   // A read completes only while requesting; pc_reset discards the data on that edge.
   assign fetch_done = (state == FETCH_OP || state == FETCH_DAT) && mem_ready && !pc_reset;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         pc_q            <= reset_vector;
         opcode_q        <= '0;
         operand_q       <= '0;
         instruction     <= '0;
         pre_data        <= '0;
         instr_valid     <= 1'b0;
         mem_read_enable <= 1'b0;
      end else begin
         state           <= state_next;
         pc_q            <= pc_next;
         opcode_q        <= opcode_next;
         operand_q       <= operand_next;
         instruction     <= instruction_next;
         pre_data        <= pre_data_next;
         instr_valid     <= valid_next;
         mem_read_enable <= read_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:      if (run) state_next = FETCH_OP;
         FETCH_OP:  if (mem_ready) state_next = is_two_word(mem_data[7:0]) ? FETCH_DAT : ISSUE;
         FETCH_DAT: if (mem_ready) state_next = ISSUE;
         ISSUE:     state_next = ir_reset ? DRAIN : EXEC;
         EXEC:      state_next = DRAIN;
         DRAIN:     state_next = run ? FETCH_OP : IDLE;
         default:   state_next = IDLE;
      endcase
      if (pc_reset) state_next = IDLE;
   end

   // Outputs are registered, so they are computed from the state being entered.
   always_comb begin
      pc_next      = pc_q;
      opcode_next  = opcode_q;
      operand_next = operand_q;
      if (ir_reset) begin
         opcode_next  = '0;
         operand_next = '0;
      end
      if (fetch_done) begin
         pc_next = pc_q + addr_width'(1);
         if (state == FETCH_OP) begin
            opcode_next  = mem_data;
            operand_next = '0;
         end else begin
            operand_next = mem_data;
         end
      end
      if (pc_reset) begin
         pc_next      = reset_vector;
         opcode_next  = '0;
         operand_next = '0;
      end
      valid_next       = (state_next == ISSUE) || (state_next == EXEC);
      read_next        = (state_next == FETCH_OP) || (state_next == FETCH_DAT);
      instruction_next = valid_next ? opcode_next : '0;
      pre_data_next    = valid_next ? operand_next : '0;
   end

   assign mem_addr = pc_q;
   assign pc       = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected issues are queued when a fetch is
// started and compared when the stage presents them; a 4-bit instance covers PC wrap.
module tb_instruction_fetch;

   logic        clk;
   logic        reset_n;
   logic        run, run_w;
   logic        pc_reset, ir_reset, mem_ready;
   logic [15:0] mem_addr, mem_data, instruction, pre_data, pc;
   logic        mem_read_enable, instr_valid;
   logic [3:0]  mem_addr_w, pc_w;
   logic [15:0] mem_data_w, instruction_w, pre_data_w;
   logic        mem_read_enable_w, instr_valid_w;

   logic [15:0] mem [0:15];
   logic [15:0] memw [0:15];

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pre;
      logic [15:0] pc_after;
   } exp_t;
   exp_t sb[$];

   int pass_count = 0;
   int total_count = 0;

   instruction_fetch u_dut (
      .clk(clk), .reset_n(reset_n), .run(run), .pc_reset(pc_reset), .ir_reset(ir_reset),
      .mem_addr(mem_addr), .mem_read_enable(mem_read_enable), .mem_data(mem_data),
      .mem_ready(mem_ready), .instruction(instruction), .pre_data(pre_data),
      .instr_valid(instr_valid), .pc(pc)
   );

   instruction_fetch #(.word_size(16), .addr_width(4), .reset_vector(4'hF)) u_wrap (
      .clk(clk), .reset_n(reset_n), .run(run_w), .pc_reset(pc_reset), .ir_reset(ir_reset),
      .mem_addr(mem_addr_w), .mem_read_enable(mem_read_enable_w), .mem_data(mem_data_w),
      .mem_ready(mem_ready), .instruction(instruction_w), .pre_data(pre_data_w),
      .instr_valid(instr_valid_w), .pc(pc_w)
   );

   assign mem_data   = (mem_addr < 16'd16) ? mem[mem_addr[3:0]] : 16'h0000;
   assign mem_data_w = memw[mem_addr_w];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_count++;
      assert (observed === expected) pass_count++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic apply_stimulus(input logic run_v, input logic ready_v);
      run       = run_v;
      mem_ready = ready_v;
   endtask

   // Waits for the next issue window, compares it with the queued expectation and
   // checks it lasts exactly two cycles before the NOP drain cycle.
   task automatic expect_issue(input int budget, input int exp_latency);
      int   n;
      exp_t e;
      n = 0;
      while (!instr_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_output("issue_seen", instr_valid, 1);
      check_output("issue_latency", n, exp_latency);
      check_output("sb_nonempty", sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_output("instr", instruction, e.instr);
         check_output("pre_data", pre_data, e.pre);
         check_output("pc_after_fetch", pc, e.pc_after);
      end
      check_output("issue_no_read", mem_read_enable, 0);
      @(negedge clk);
      check_output("exec_valid", instr_valid, 1);
      check_output("exec_instr", instruction, e.instr);
      check_output("exec_no_read", mem_read_enable, 0);
      @(negedge clk);
      check_output("drain_valid", instr_valid, 0);
      check_output("drain_instr", instruction, 0);
      check_output("drain_pre", pre_data, 0);
      check_output("drain_no_read", mem_read_enable, 0);
   endtask

   initial begin
      int   seen;
      int   n;
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         mem[i]  = 16'h0000;
         memw[i] = 16'h0000;
      end
      reset_n = 1'b0; run = 1'b0; run_w = 1'b0;
      pc_reset = 1'b0; ir_reset = 1'b0; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      check_output("rst_pc", pc, 0);
      check_output("rst_addr", mem_addr, 0);
      check_output("rst_valid", instr_valid, 0);
      check_output("rst_instr", instruction, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_output("idle_no_read", mem_read_enable, 0);
      end

      // One-word, zero-wait, then a second back-to-back fetch
      mem[0] = 16'h0014;
      mem[1] = 16'h0010;
      sb.push_back('{16'h0014, 16'h0000, 16'h0001});
      apply_stimulus(1'b1, 1'b1);
      @(negedge clk);
      check_output("fo_read", mem_read_enable, 1);
      check_output("fo_addr", mem_addr, 0);
      expect_issue(8, 1);
      @(negedge clk);
      check_output("refetch_read", mem_read_enable, 1);
      check_output("refetch_addr", mem_addr, 1);
      run = 1'b0;
      sb.push_back('{16'h0010, 16'h0000, 16'h0002});
      expect_issue(8, 1);
      @(negedge clk);
      check_output("idle_after_run0", mem_read_enable, 0);
      check_output("pc_two", pc, 2);

      // Two-word with two wait cycles per read
      pc_reset = 1'b1;
      @(negedge clk);
      pc_reset = 1'b0;
      check_output("pc_reset_idle", pc, 0);
      mem[0] = 16'h0203;
      mem[1] = 16'h1234;
      sb.push_back('{16'h0203, 16'h1234, 16'h0002});
      apply_stimulus(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         run = 1'b0;
         check_output("wait_op_addr", mem_addr, 0);
         check_output("wait_op_read", mem_read_enable, 1);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      check_output("dat_pc", pc, 1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         check_output("wait_dat_addr", mem_addr, 1);
         check_output("wait_dat_read", mem_read_enable, 1);
      end
      mem_ready = 1'b1;
      expect_issue(4, 1);
      @(negedge clk);
      check_output("two_word_idle", mem_read_enable, 0);

      // pc_reset in a FETCH_DAT wait while mem_ready rises on the same edge
      mem[2] = 16'h0101;
      mem[3] = 16'hBEEF;
      apply_stimulus(1'b1, 1'b1);
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      check_output("abort_dat_pc", pc, 3);
      mem_ready = 1'b0;
      @(negedge clk);
      check_output("abort_wait_addr", mem_addr, 3);
      mem_ready = 1'b1;
      pc_reset = 1'b1;
      @(negedge clk);
      pc_reset = 1'b0;
      check_output("abort_pc", pc, 0);
      check_output("abort_read", mem_read_enable, 0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (instr_valid) seen = 1;
      end
      check_output("abort_no_issue", seen, 0);

      // ir_reset during ISSUE
      mem[0] = 16'h1F1F;
      mem[1] = 16'h00FF;
      mem[2] = 16'h0015;
      sb.push_back('{16'h1F1F, 16'h00FF, 16'h0002});
      apply_stimulus(1'b1, 1'b1);
      n = 0;
      while (!instr_valid && n < 6) begin
         @(negedge clk);
         n++;
      end
      check_output("ir_issue_seen", instr_valid, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_output("ir_instr", instruction, e.instr);
         check_output("ir_pre", pre_data, e.pre);
         check_output("ir_pc", pc, e.pc_after);
      end
      ir_reset = 1'b1;
      @(negedge clk);
      ir_reset = 1'b0;
      check_output("ir_cleared_instr", instruction, 0);
      check_output("ir_cleared_pre", pre_data, 0);
      check_output("ir_cleared_valid", instr_valid, 0);
      @(negedge clk);
      check_output("ir_next_read", mem_read_enable, 1);
      check_output("ir_next_addr", mem_addr, 2);
      run = 1'b0;
      sb.push_back('{16'h0015, 16'h0000, 16'h0003});
      expect_issue(4, 1);

      // Asynchronous reset in the middle of a stalled fetch
      mem[3] = 16'h0014;
      apply_stimulus(1'b1, 1'b0);
      @(negedge clk);
      run = 1'b0;
      check_output("pre_rst_read", mem_read_enable, 1);
      #2 reset_n = 1'b0;
      #1;
      check_output("async_read", mem_read_enable, 0);
      check_output("async_valid", instr_valid, 0);
      check_output("async_instr", instruction, 0);
      check_output("async_pre", pre_data, 0);
      check_output("async_addr", mem_addr, 0);
      check_output("async_pc", pc, 0);
      @(negedge clk);
      reset_n = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("post_rst_idle", mem_read_enable, 0);
      end

      // PC wrap on the 4-bit instance
      memw[15] = 16'h0012;
      memw[0]  = 16'h0010;
      check_output("wrap_start_pc", pc_w, 4'hF);
      run_w = 1'b1;
      @(negedge clk);
      check_output("wrap_addr15", mem_addr_w, 4'hF);
      check_output("wrap_read15", mem_read_enable_w, 1);
      @(negedge clk);
      check_output("wrap_pc0", pc_w, 0);
      check_output("wrap_instr", instruction_w, 16'h0012);
      check_output("wrap_pre", pre_data_w, 0);
      repeat (3) @(negedge clk);
      check_output("wrap_next_addr", mem_addr_w, 0);
      check_output("wrap_next_read", mem_read_enable_w, 1);
      run_w = 1'b0;
      @(negedge clk);
      check_output("wrap_next_instr", instruction_w, 16'h0010);
      check_output("wrap_next_pc", pc_w, 1);

      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
